sample_readout: RTL and testbench

- Drains the sample stream produced by the sample collection memory out to the host over the EBI bus.
- The collection side pushes 16-bit samples with write_enable/sample_data; the block buffers them in a circular FIFO.
- The host reads them through a small register window decoded from the shared EBI address bus.
- Sits beside the collection memory, on the same configuration bus, at its own POSITION.

---
 rtl/sample_readout_if.sv | 24 ++
 rtl/sample_readout.sv | 105 ++++++++++
 tb/tb_sample_readout.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_readout_if.sv
// EBI register-window bus plus collection-side push port and FIFO status for sample_readout.
interface sample_readout_if;
  logic [18:0] addr;
  logic [15:0] ebi_data_in;
  logic [15:0] ebi_data_out;
  logic        enable;
  logic        re;
  logic        wr;
  logic        write_enable;
  logic [15:0] sample_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;

  modport master (
    output addr, ebi_data_in, enable, re, wr, write_enable, sample_data,
    input  ebi_data_out, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  addr, ebi_data_in, enable, re, wr, write_enable, sample_data,
    output ebi_data_out, fifo_full, fifo_empty, overflow
  );
endinterface

// File: rtl/sample_readout.sv
// Circular sample FIFO fed by the collection memory and drained by the host through
// an edge-triggered EBI register window (DATA / COUNT / STATUS / CTRL).
module sample_readout #(
  parameter logic [10:0] POSITION   = 11'd0,
  parameter int          DEPTH_LOG2 = 9
) (
  input  logic            clk,
  input  logic            rst,
  sample_readout_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [DATA_W-1:0] mem [DEPTH];

  ptr_t              wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  cnt_t              count, count_nxt;
  logic              re_d, wr_d;
  logic              ovf_r, full_r, empty_r;
  logic [DATA_W-1:0] dout_r;
  logic [DATA_W-1:0] rd_q_p1, byp_data_p1;
  logic              byp_p1;

  logic              sel, rd_pulse, wr_pulse, ctrl_wr;
  logic              flush, clr_ovf, pop, push, drop;
  logic [DATA_W-1:0] head, rd_val;

  always_comb begin
    sel      = bus.enable && (bus.addr[18:8] == POSITION);
    rd_pulse = sel && bus.re && !re_d;
    wr_pulse = sel && bus.wr && !wr_d;
    ctrl_wr  = wr_pulse && (bus.addr[3:0] == 4'd3);
    flush    = ctrl_wr && bus.ebi_data_in[0];
    clr_ovf  = ctrl_wr && bus.ebi_data_in[1];
    pop      = rd_pulse && (bus.addr[3:0] == 4'd0) && (count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push     = bus.write_enable && !flush && ((count != CNT_FULL) || pop);
    drop     = bus.write_enable && !flush && (count == CNT_FULL) && !pop;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      wr_ptr_nxt = wr_ptr + ptr_t'(push);
      rd_ptr_nxt = rd_ptr + ptr_t'(pop);
      count_nxt  = count + cnt_t'(push) - cnt_t'(pop);
    end

    // RAM output lags one cycle; a word written into the head slot is forwarded.
    head = byp_p1 ? byp_data_p1 : rd_q_p1;

    case (bus.addr[3:0])
      4'd0:    rd_val = (count != '0) ? head : '0;
      4'd1:    rd_val = DATA_W'(count);
      4'd2:    rd_val = {13'b0, ovf_r, full_r, empty_r};
      default: rd_val = '0;
    endcase
  end

  // p0 -> p1: RAM write and registered read of the next head slot
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.sample_data;
    rd_q_p1     <= mem[rd_ptr_nxt];
    byp_data_p1 <= bus.sample_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      re_d    <= 1'b0;
      wr_d    <= 1'b0;
      ovf_r   <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      dout_r  <= '0;
      byp_p1  <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      re_d    <= bus.re;
      wr_d    <= bus.wr;
      full_r  <= (count_nxt == CNT_FULL);
      empty_r <= (count_nxt == '0);
      byp_p1  <= push && (wr_ptr == rd_ptr_nxt);
      if (drop)         ovf_r <= 1'b1;
      else if (clr_ovf) ovf_r <= 1'b0;
      if (rd_pulse)     dout_r <= rd_val;
    end
  end

  assign bus.ebi_data_out = dout_r;
  assign bus.fifo_full    = full_r;
  assign bus.fifo_empty   = empty_r;
  assign bus.overflow     = ovf_r;

endmodule

// File: tb/tb_sample_readout.sv
// Randomized and directed bench for sample_readout against a queue-based reference model.
module tb_sample_readout;

  localparam logic [10:0] POS = 11'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_readout_if bus ();

  sample_readout #(.POSITION(POS), .DEPTH_LOG2(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] q[$];
  bit          m_ovf;
  logic [15:0] m_dout;
  bit          m_re_d, m_wr_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit sel, rdp, wrp, pop, flush, clr, drop;
    logic [3:0] off;
    int sz;
    if (!rst) begin
      q.delete();
      m_ovf  = 0;
      m_dout = '0;
      m_re_d = 0;
      m_wr_d = 0;
    end else begin
      sz   = q.size();
      off  = bus.addr[3:0];
      sel  = bus.enable && (bus.addr[18:8] == POS);
      rdp  = sel && bus.re && !m_re_d;
      wrp  = sel && bus.wr && !m_wr_d;
      m_re_d = bus.re;
      m_wr_d = bus.wr;
      if (rdp) begin
        case (off)
          4'd0:    m_dout = (sz > 0) ? q[0] : 16'h0000;
          4'd1:    m_dout = 16'(sz);
          4'd2:    m_dout = {13'b0, m_ovf, sz == 512, sz == 0};
          default: m_dout = 16'h0000;
        endcase
      end
      pop   = rdp && off == 4'd0 && sz > 0;
      flush = wrp && off == 4'd3 && bus.ebi_data_in[0];
      clr   = wrp && off == 4'd3 && bus.ebi_data_in[1];
      drop  = 0;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (bus.write_enable) begin
          if (sz < 512 || pop) q.push_back(bus.sample_data);
          else drop = 1;
        end
      end
      if (drop)     m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("dout", 32'(bus.ebi_data_out), 32'(m_dout));
    check("flags", {29'b0, bus.overflow, bus.fifo_full, bus.fifo_empty},
          {29'b0, m_ovf, q.size() == 512, q.size() == 0});
  endtask

  task automatic idle();
    bus.enable = 0; bus.re = 0; bus.wr = 0; bus.write_enable = 0;
  endtask

  task automatic push(input logic [15:0] d);
    bus.write_enable = 1;
    bus.sample_data  = d;
    tick();
    bus.write_enable = 0;
  endtask

  task automatic host_read(input logic [3:0] off, input int hold, input logic [15:0] exp,
                           input logic [10:0] pos = POS);
    bus.addr   = {pos, 4'b0, off};
    bus.enable = 1;
    bus.re     = 1;
    repeat (hold) tick();
    bus.re     = 0;
    bus.enable = 0;
    tick();
    check("read", 32'(bus.ebi_data_out), 32'(exp));
  endtask

  task automatic host_write(input logic [3:0] off, input logic [15:0] d);
    bus.addr        = {POS, 4'b0, off};
    bus.ebi_data_in = d;
    bus.enable      = 1;
    bus.wr          = 1;
    tick();
    bus.wr     = 0;
    bus.enable = 0;
    tick();
  endtask

  initial begin
    rst = 0;
    bus.addr = '0; bus.ebi_data_in = '0; bus.sample_data = '0;
    idle();
    repeat (2) tick();
    check("rst_status", {29'b0, bus.overflow, bus.fifo_full, bus.fifo_empty}, 32'h1);
    rst = 1;
    tick();

    // Reset with a partially filled FIFO and a nonzero read register
    for (int i = 0; i < 5; i++) push(16'h7700 + 16'(i));
    host_read(4'd0, 1, 16'h7700);
    rst = 0;
    tick();
    check("rst_dout", 32'(bus.ebi_data_out), 32'h0);
    rst = 1;
    tick();
    host_read(4'd1, 1, 16'd0);
    host_read(4'd2, 1, 16'h0001);

    // One pop per held strobe
    push(16'hA001); push(16'hA002); push(16'hA003);
    host_read(4'd0, 4, 16'hA001);
    host_read(4'd0, 4, 16'hA002);
    host_read(4'd0, 4, 16'hA003);
    host_read(4'd2, 1, 16'h0001);

    // Overfill: 513th sample lost
    for (int i = 0; i < 513; i++) push(16'h4000 + 16'(i));
    host_read(4'd1, 1, 16'd512);
    host_read(4'd2, 1, 16'h0006);
    for (int i = 0; i < 512; i++) host_read(4'd0, 1, 16'h4000 + 16'(i));
    host_read(4'd2, 1, 16'h0005);
    host_write(4'd3, 16'h0002);
    host_read(4'd2, 1, 16'h0001);

    // Full: simultaneous push and pop, then drain across the pointer wrap
    for (int i = 0; i < 512; i++) push(16'h5000 + 16'(i));
    bus.addr = {POS, 8'h00}; bus.enable = 1; bus.re = 1;
    bus.write_enable = 1; bus.sample_data = 16'h5EEE;
    tick();
    idle();
    tick();
    check("full_pp_dout", 32'(bus.ebi_data_out), 32'h5000);
    check("full_pp_ovf", 32'(bus.overflow), 32'h0);
    host_read(4'd1, 1, 16'd512);
    for (int i = 1; i < 512; i++) host_read(4'd0, 1, 16'h5000 + 16'(i));
    host_read(4'd0, 1, 16'h5EEE);

    // Empty read, then clear-overflow racing a new overflow
    host_read(4'd0, 1, 16'h0000);
    host_read(4'd1, 1, 16'd0);
    for (int i = 0; i < 513; i++) push(16'h6000 + 16'(i));
    bus.addr = {POS, 8'h03}; bus.ebi_data_in = 16'h0002; bus.enable = 1; bus.wr = 1;
    bus.write_enable = 1; bus.sample_data = 16'h6FFF;
    tick();
    idle();
    tick();
    host_read(4'd2, 1, 16'h0006);

    // Unselected block: no pop, output unchanged
    host_read(4'd0, 1, 16'h0006, 11'd2);
    host_read(4'd1, 1, 16'd512);

    // Flush mid-stream
    host_read(4'd0, 1, 16'h6000);
    host_write(4'd3, 16'h0001);
    host_read(4'd1, 1, 16'd0);
    host_read(4'd0, 1, 16'h0000);
    host_write(4'd3, 16'h0002);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 600; c++) begin
        bus.enable       = ($urandom_range(0, 9) != 0);
        bus.addr         = {($urandom_range(0, 7) == 0) ? 11'd2 : POS, 4'b0,
                            4'($urandom_range(0, 5))};
        bus.re           = $urandom_range(0, 1);
        bus.wr           = ($urandom_range(0, 9) == 0);
        bus.ebi_data_in  = {14'($urandom), ($urandom_range(0, 1) == 0), ($urandom_range(0, 24) == 0)};
        bus.write_enable = (ph % 2 == 0) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 2);
        bus.sample_data  = 16'($urandom);
        tick();
      end
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
